// File: rtl/wb_arbiter.sv
// Writeback arbiter: fairly merges ALU and LSU results into one registered
// register-file write per cycle and forwards the in-flight write to decode.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] fwd_rs1,
    input  logic [ADDR_WIDTH-1:0] fwd_rs2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [DATA_WIDTH-1:0] fwd2_data,
    output logic [31:0]           wb_count
);

    logic                  last_lsu_q, last_lsu_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]           wb_count_q, wb_count_d;
    logic                  grant_alu, grant_lsu;

    // Under contention the source that did not win last time goes first.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                grant_lsu = !last_lsu_q;
                grant_alu = last_lsu_q;
            end else begin
                grant_alu = alu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    always_comb begin
        last_lsu_d = last_lsu_q;
        if (alu_valid && lsu_valid) begin
            last_lsu_d = grant_lsu;
        end

        rf_wen_d   = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_lsu) begin
            rf_rd_d    = lsu_rd;
            rf_wdata_d = lsu_data;
            rf_wen_d   = (lsu_rd != '0);
        end else if (grant_alu) begin
            rf_rd_d    = alu_rd;
            rf_wdata_d = alu_data;
            rf_wen_d   = (alu_rd != '0);
        end

        wb_count_d = wb_count_q + {31'd0, rf_wen_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            wb_count_q <= '0;
        end else begin
            last_lsu_q <= last_lsu_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign rf_wen    = rf_wen_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;
    assign wb_count  = wb_count_q;

    // Forwarding is suppressed during reset so decode never sees a stale stage.
    assign fwd1_hit  = !rst && rf_wen_q && (fwd_rs1 == rf_rd_q);
    assign fwd2_hit  = !rst && rf_wen_q && (fwd_rs2 == rf_rd_q);
    assign fwd1_data = fwd1_hit ? rf_wdata_q : '0;
    assign fwd2_data = fwd2_hit ? rf_wdata_q : '0;

endmodule
